// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
// Shared definitions for the EX->MEM pipeline register slice:
//   - default field widths used as parameter defaults by the interface/top
//   - stage state encoding (RUN / HALTED, 1 bit, RUN = 0)
//   - the fill bit used to build a bubble (every field all zeros)
package ex_mem_pkg;

    localparam int DEF_NB_DATA     = 32;
    localparam int DEF_NB_REGWR    = 5;
    localparam int DEF_NB_PC       = 7;
    localparam int DEF_NB_MEM_CTRL = 6;
    localparam int DEF_NB_WB_CTRL  = 2;
    localparam int DEF_NB_CNT      = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // A bubble is every field replicated from this bit. Zeroed MEM/WB
    // controls guarantee no memory write and no register-file write.
    localparam logic BUBBLE_FILL = 1'b0;

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if
// Bundles the EX->MEM stage signals (everything except clock and reset).
//   master: the EX side / debug unit, drives *_i plus en_pipeline/flush_i
//   slave : the pipeline register, drives *_o
// Handshake: there is no ready. valid_i qualifies the entry on the edge it
// is sampled; en_pipeline=0 is a stall (stage holds), flush_i replaces the
// incoming entry with a bubble. valid_o qualifies the registered entry.
interface ex_mem_pipe_reg_if
    import ex_mem_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int NB_REGWR    = DEF_NB_REGWR,
    parameter int NB_PC       = DEF_NB_PC,
    parameter int NB_MEM_CTRL = DEF_NB_MEM_CTRL,
    parameter int NB_WB_CTRL  = DEF_NB_WB_CTRL,
    parameter int NB_CNT      = DEF_NB_CNT
);
    logic                   en_pipeline;
    logic                   flush_i;
    logic                   valid_i;
    logic                   halt_i;
    logic [NB_DATA-1:0]     data_wr_to_mem_i;
    logic [NB_DATA-1:0]     alu_result_i;
    logic [NB_REGWR-1:0]    writeReg_i;
    logic [NB_PC-1:0]       pc_i;
    logic [NB_MEM_CTRL-1:0] mem_signals_i;
    logic [NB_WB_CTRL-1:0]  wb_signals_i;

    logic [NB_DATA-1:0]     data_wr_to_mem_o;
    logic [NB_DATA-1:0]     alu_result_o;
    logic [NB_REGWR-1:0]    writeReg_o;
    logic [NB_PC-1:0]       pc_o;
    logic [NB_MEM_CTRL-1:0] mem_signals_o;
    logic [NB_WB_CTRL-1:0]  wb_signals_o;
    logic                   valid_o;
    logic                   halt_o;
    logic                   halted_o;
    logic [NB_CNT-1:0]      count_o;

    modport master (
        output en_pipeline, flush_i, valid_i, halt_i, data_wr_to_mem_i,
               alu_result_i, writeReg_i, pc_i, mem_signals_i, wb_signals_i,
        input  data_wr_to_mem_o, alu_result_o, writeReg_o, pc_o,
               mem_signals_o, wb_signals_o, valid_o, halt_o, halted_o, count_o
    );

    modport slave (
        input  en_pipeline, flush_i, valid_i, halt_i, data_wr_to_mem_i,
               alu_result_i, writeReg_i, pc_i, mem_signals_i, wb_signals_i,
        output data_wr_to_mem_o, alu_result_o, writeReg_o, pc_o,
               mem_signals_o, wb_signals_o, valid_o, halt_o, halted_o, count_o
    );

endinterface

// File: rtl/ex_mem_pipe_reg_pipe_field_reg.sv
// pipe_field_reg
// One pipeline field: falling-edge register with synchronous active-high
// reset, clear (load a bubble) and load enable. Clear beats load.
//   clk_i, rst_i      : clock (falling edge) and sync reset
//   load_i, clear_i   : load d_i / load the bubble value
//   d_i, q_o          : field in / registered field out
module pipe_field_reg
    import ex_mem_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = {W{BUBBLE_FILL}};
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
// EX->MEM pipeline register with valid tracking, flush, halt capture with a
// sticky freeze, and a saturating count of valid entries loaded.
//   clock_i : clock, all state updates on the falling edge
//   reset_i : synchronous active-high reset
//   bus     : stage inputs/outputs (see ex_mem_pipe_reg_if); halted_o is
//             the FSM state bit (1 = HALTED)
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int NB_REGWR    = DEF_NB_REGWR,
    parameter int NB_PC       = DEF_NB_PC,
    parameter int NB_MEM_CTRL = DEF_NB_MEM_CTRL,
    parameter int NB_WB_CTRL  = DEF_NB_WB_CTRL,
    parameter int NB_CNT      = DEF_NB_CNT
) (
    input logic               clock_i,
    input logic               reset_i,
    ex_mem_pipe_reg_if.slave  bus
);
    state_e            state_q;
    state_e            state_d;
    logic              load;
    logic              clear;
    logic              halt_d;
    logic [NB_CNT-1:0] count_q;
    logic [NB_CNT-1:0] count_d;

    // State register
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only a real HALT entry on a normal load enters HALTED;
    // HALTED is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!bus.flush_i && bus.en_pipeline && bus.valid_i && bus.halt_i) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Outputs: flush beats stall; HALTED freezes everything.
    always_comb begin
        load  = 1'b0;
        clear = 1'b0;
        if (state_q == ST_RUN) begin
            if (bus.flush_i) begin
                clear = 1'b1;
            end else if (bus.en_pipeline) begin
                load = 1'b1;
            end
        end
    end

    assign bus.halted_o = (state_q == ST_HALTED);

    // A halt flag on a non-valid entry means nothing downstream.
    assign halt_d = bus.halt_i & bus.valid_i;

    // Retired-entry counter, saturating at all ones.
    always_comb begin
        count_d = count_q;
        if (load && bus.valid_i && (count_q != {NB_CNT{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count_o = count_q;

    pipe_field_reg #(.W(NB_DATA)) u_data (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.data_wr_to_mem_i), .q_o(bus.data_wr_to_mem_o)
    );
    pipe_field_reg #(.W(NB_DATA)) u_alu (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.alu_result_i), .q_o(bus.alu_result_o)
    );
    pipe_field_reg #(.W(NB_REGWR)) u_wreg (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.writeReg_i), .q_o(bus.writeReg_o)
    );
    pipe_field_reg #(.W(NB_PC)) u_pc (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.pc_i), .q_o(bus.pc_o)
    );
    pipe_field_reg #(.W(NB_MEM_CTRL)) u_mem (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.mem_signals_i), .q_o(bus.mem_signals_o)
    );
    pipe_field_reg #(.W(NB_WB_CTRL)) u_wb (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.wb_signals_i), .q_o(bus.wb_signals_o)
    );
    pipe_field_reg #(.W(1)) u_valid (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(bus.valid_i), .q_o(bus.valid_o)
    );
    pipe_field_reg #(.W(1)) u_halt (
        .clk_i(clock_i), .rst_i(reset_i), .load_i(load), .clear_i(clear),
        .d_i(halt_d), .q_o(bus.halt_o)
    );

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;
    import ex_mem_pkg::*;

    typedef struct {
        logic        rst, en, flush, valid, halt;
        logic [31:0] data, alu;
        logic [4:0]  wreg;
        logic [6:0]  pc;
        logic [5:0]  mem;
        logic [1:0]  wb;
        logic [31:0] e_data, e_alu;
        logic [4:0]  e_wreg;
        logic [6:0]  e_pc;
        logic [5:0]  e_mem;
        logic [1:0]  e_wb;
        logic        e_valid, e_halt, e_halted;
        logic [15:0] e_count;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    ex_mem_pipe_reg_if #(.NB_CNT(16)) bus_a ();
    ex_mem_pipe_reg_if #(.NB_CNT(3))  bus_b ();

    ex_mem_pipe_reg #(.NB_CNT(16)) dut_a (
        .clock_i(clk), .reset_i(rst_a), .bus(bus_a)
    );
    ex_mem_pipe_reg #(.NB_CNT(3)) dut_b (
        .clock_i(clk), .reset_i(rst_b), .bus(bus_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic rst, en, flush, valid, halt,
        input logic [31:0] data, alu, input logic [4:0] wreg,
        input logic [6:0] pc, input logic [5:0] mem, input logic [1:0] wb,
        input logic [31:0] e_data, e_alu, input logic [4:0] e_wreg,
        input logic [6:0] e_pc, input logic [5:0] e_mem, input logic [1:0] e_wb,
        input logic e_valid, e_halt, e_halted, input logic [15:0] e_count);
        vec_t r;
        r.rst = rst; r.en = en; r.flush = flush; r.valid = valid; r.halt = halt;
        r.data = data; r.alu = alu; r.wreg = wreg; r.pc = pc; r.mem = mem; r.wb = wb;
        r.e_data = e_data; r.e_alu = e_alu; r.e_wreg = e_wreg; r.e_pc = e_pc;
        r.e_mem = e_mem; r.e_wb = e_wb; r.e_valid = e_valid; r.e_halt = e_halt;
        r.e_halted = e_halted; r.e_count = e_count;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Driver: apply one vector to dut_a, wait one falling edge, settle.
    task automatic drive_a(input vec_t x);
        rst_a                  = x.rst;
        bus_a.en_pipeline      = x.en;
        bus_a.flush_i          = x.flush;
        bus_a.valid_i          = x.valid;
        bus_a.halt_i           = x.halt;
        bus_a.data_wr_to_mem_i = x.data;
        bus_a.alu_result_i     = x.alu;
        bus_a.writeReg_i       = x.wreg;
        bus_a.pc_i             = x.pc;
        bus_a.mem_signals_i    = x.mem;
        bus_a.wb_signals_i     = x.wb;
        @(negedge clk);
        #1;
    endtask

    task automatic drive_b(input logic rst, input logic valid);
        rst_b                  = rst;
        bus_b.en_pipeline      = 1'b1;
        bus_b.flush_i          = 1'b0;
        bus_b.valid_i          = valid;
        bus_b.halt_i           = 1'b0;
        bus_b.data_wr_to_mem_i = 32'h0;
        bus_b.alu_result_i     = 32'h1;
        bus_b.writeReg_i       = 5'd1;
        bus_b.pc_i             = 7'd1;
        bus_b.mem_signals_i    = 6'h0;
        bus_b.wb_signals_i     = 2'h0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.en_pipeline = 1'b0; bus_a.flush_i = 1'b0; bus_a.valid_i = 1'b0;
        bus_a.halt_i = 1'b0; bus_a.data_wr_to_mem_i = '0; bus_a.alu_result_i = '0;
        bus_a.writeReg_i = '0; bus_a.pc_i = '0; bus_a.mem_signals_i = '0;
        bus_a.wb_signals_i = '0;
        bus_b.en_pipeline = 1'b0; bus_b.flush_i = 1'b0; bus_b.valid_i = 1'b0;
        bus_b.halt_i = 1'b0; bus_b.data_wr_to_mem_i = '0; bus_b.alu_result_i = '0;
        bus_b.writeReg_i = '0; bus_b.pc_i = '0; bus_b.mem_signals_i = '0;
        bus_b.wb_signals_i = '0;

        //          rst en fl va ha  data      alu          wreg pc  mem    wb  | e_data    e_alu        wreg pc  mem    wb  v  h  hd cnt
        // reset
        vecs.push_back(v(1,0,0,0,0, 'h1111,   'h2222,      2,   3,  6'h01, 1,  0,        0,           0,   0,  0,     0,  0, 0, 0, 0));
        // first load
        vecs.push_back(v(0,1,0,1,0, 'h1234,   'hA5,        9,   4,  6'h05, 1,  'h1234,   'hA5,        9,   4,  6'h05, 1,  1, 0, 0, 1));
        // three stall edges while inputs change
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,0,1,0, 'hDEAD, 'hFFFF_FFFF, 3,  10, 6'h0A, 2,  'h1234,   'hA5,        9,   4,  6'h05, 1,  1, 0, 0, 1));
        // re-enable
        vecs.push_back(v(0,1,0,1,0, 'hDEAD,   'hFFFF_FFFF, 3,   10, 6'h0A, 2,  'hDEAD,   'hFFFF_FFFF, 3,   10, 6'h0A, 2,  1, 0, 0, 2));
        // flush during stall -> bubble, count unchanged
        vecs.push_back(v(0,0,1,1,0, 'hBEEF,   'h42,        4,   11, 6'h3F, 3,  0,        0,           0,   0,  0,     0,  0, 0, 0, 2));
        // ordinary valid load
        vecs.push_back(v(0,1,0,1,0, 'h77,     'h55,        7,   8,  6'h11, 1,  'h77,     'h55,        7,   8,  6'h11, 1,  1, 0, 0, 3));
        // halt without valid: ignored, fields still load, no count
        vecs.push_back(v(0,1,0,0,1, 'h66,     'h66,        1,   9,  6'h00, 0,  'h66,     'h66,        1,   9,  0,     0,  0, 0, 0, 3));
        // real HALT entry
        vecs.push_back(v(0,1,0,1,1, 'hAB,     'h99,        31,  20, 6'h02, 3,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        // frozen in HALTED through flush, stall, loads
        vecs.push_back(v(0,1,1,1,0, 'h1,      'h2,         3,   4,  6'h3F, 3,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        vecs.push_back(v(0,0,1,0,0, 'h5,      'h6,         7,   8,  6'h10, 1,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        vecs.push_back(v(0,1,0,1,0, 'h9,      'hA,         11,  12, 6'h20, 2,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        vecs.push_back(v(0,1,0,1,1, 'hC,      'hD,         13,  14, 6'h30, 1,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        vecs.push_back(v(0,0,0,1,0, 'hE,      'hF,         15,  16, 6'h01, 0,  'hAB,     'h99,        31,  20, 6'h02, 3,  1, 1, 1, 4));
        // reset leaves HALTED
        vecs.push_back(v(1,1,0,1,1, 'hE,      'hF,         15,  16, 6'h01, 0,  0,        0,           0,   0,  0,     0,  0, 0, 0, 0));
        // back in RUN: loads again
        vecs.push_back(v(0,1,0,1,0, 'h31,     'h32,        17,  18, 6'h04, 2,  'h31,     'h32,        17,  18, 6'h04, 2,  1, 0, 0, 1));
        // stall, then reset during the stall
        vecs.push_back(v(0,0,0,1,0, 'h41,     'h42,        19,  21, 6'h08, 1,  'h31,     'h32,        17,  18, 6'h04, 2,  1, 0, 0, 1));
        vecs.push_back(v(1,0,0,1,0, 'h41,     'h42,        19,  21, 6'h08, 1,  0,        0,           0,   0,  0,     0,  0, 0, 0, 0));
        // flush beats a load with en=1
        vecs.push_back(v(0,1,1,1,1, 'h51,     'h52,        22,  23, 6'h0C, 3,  0,        0,           0,   0,  0,     0,  0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive_a(vecs[i]);
            chk("data",   i, 32'(bus_a.data_wr_to_mem_o), vecs[i].e_data);
            chk("alu",    i, 32'(bus_a.alu_result_o),     vecs[i].e_alu);
            chk("wreg",   i, 32'(bus_a.writeReg_o),       32'(vecs[i].e_wreg));
            chk("pc",     i, 32'(bus_a.pc_o),             32'(vecs[i].e_pc));
            chk("mem",    i, 32'(bus_a.mem_signals_o),    32'(vecs[i].e_mem));
            chk("wb",     i, 32'(bus_a.wb_signals_o),     32'(vecs[i].e_wb));
            chk("valid",  i, 32'(bus_a.valid_o),          32'(vecs[i].e_valid));
            chk("halt",   i, 32'(bus_a.halt_o),           32'(vecs[i].e_halt));
            chk("halted", i, 32'(bus_a.halted_o),         32'(vecs[i].e_halted));
            chk("count",  i, 32'(bus_a.count_o),          32'(vecs[i].e_count));
        end

        // Saturation on a 3-bit counter: 1..7 then stuck at 7.
        drive_b(1'b1, 1'b1);
        chk("sat_reset", 0, 32'(bus_b.count_o), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            drive_b(1'b0, 1'b1);
            chk("sat_count", i, 32'(bus_b.count_o), (i > 7) ? 32'd7 : 32'(i));
        end
        // invalid loads do not count
        drive_b(1'b1, 1'b0);
        drive_b(1'b0, 1'b0);
        chk("sat_invalid", 10, 32'(bus_b.count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX→MEM pipeline register for the MIPS datapath. Carries the store data, ALU result, destination register, PC and MEM/WB control fields from EX to MEM. Adds per-entry valid tracking, flush (bubble insertion), halt capture with a sticky freeze, and a saturating retired-entry counter read by the debug unit.

Parameters:
NB_DATA, 32, width of store data and ALU result
NB_REGWR, 5, destination register index width
NB_PC, 7, PC width (instruction memory address)
NB_MEM_CTRL, 6, MEM-stage control field width
NB_WB_CTRL, 2, WB-stage control field width
NB_CNT, 16, retired-entry counter width

Ports:
clock_i  in  1  clock; all registers update on the falling edge
reset_i  in  1  synchronous, active-high reset
en_pipeline  in  1  stage enable from the debug unit/hazard logic; 0 = stall (hold)
flush_i  in  1  replace the incoming entry with a bubble
valid_i  in  1  incoming entry is a real instruction
halt_i  in  1  incoming entry is the HALT instruction
data_wr_to_mem_i  in  NB_DATA  store data
alu_result_i  in  NB_DATA  ALU result / memory address
writeReg_i  in  NB_REGWR  destination register
pc_i  in  NB_PC  PC of the entry
mem_signals_i  in  NB_MEM_CTRL  MEM control
wb_signals_i  in  NB_WB_CTRL  WB control
data_wr_to_mem_o, alu_result_o, writeReg_o, pc_o, mem_signals_o, wb_signals_o  out  same widths as inputs  registered copies
valid_o  out  1  registered valid
halt_o  out  1  registered halt flag of the current entry
halted_o  out  1  stage is in HALTED state
count_o  out  NB_CNT  number of valid entries loaded since reset, saturating

Behaviour:
- Single clock, falling-edge registers; reset is synchronous, active-high, sampled on the same edge.
- Reset: all data/control outputs 0, valid_o=0, halt_o=0, halted_o=0, count_o=0, state=RUN. Reset mid-HALTED or mid-stall returns to RUN on that edge.
- Latency: one falling edge from inputs to outputs; outputs are purely registered, no combinational input→output path.
- State machine: RUN, HALTED (1-bit encoding, RUN=0).
- RUN, priority per edge: flush_i=1 → bubble load (all data/control fields 0, valid_o=0, halt_o=0), regardless of en_pipeline; else en_pipeline=0 → hold every register; else normal load of all fields, with valid_o<=valid_i and halt_o<=halt_i&valid_i.
- A normal load with valid_i=1 and halt_i=1 moves to HALTED on the same edge, so halted_o=1 together with halt_o=1.
- HALTED: every register holds; en_pipeline and flush_i are ignored. Only reset exits.
- halt_i with valid_i=0 is ignored: no state change, halt_o=0.
- Counter: increments by 1 on each normal load with valid_i=1, including the HALT entry. No increment on a bubble, a stall, or in HALTED. Saturates at 2^NB_CNT-1 with no wrap.
- Flush and stall in the same cycle: flush wins and the bubble is loaded.
- Control fields are zeroed on a bubble so that MEM never writes memory and WB never writes the register file.

Decomposition:
- Shared package ex_mem_pkg: default width constants (NB_DATA, NB_REGWR, NB_PC, NB_MEM_CTRL, NB_WB_CTRL), the state encoding (ST_RUN, ST_HALTED) and the bubble value (all zeros).
- One sub-module, pipe_field_reg: a width-parametrised falling-edge register with sync reset, load enable and clear. It is instantiated once per field; the FSM and counter live in the top module.

Test Plan:
- Reset, then load alu_result_i=0x0000_00A5, writeReg_i=5'd9, pc_i=7'd4, valid_i=1 with en_pipeline=1 → one falling edge later: outputs equal inputs, valid_o=1, count_o=1.
- en_pipeline=0 for 3 edges while inputs change to alu_result_i=0xFFFF_FFFF → outputs stay 0x0000_00A5 and count_o stays 1; re-enable → new value appears on the next edge and count_o=2.
- flush_i=1 with en_pipeline=0, mem_signals_i=6'h3F → next edge: mem_signals_o=0, wb_signals_o=0, valid_o=0, count_o unchanged.
- valid_i=1, halt_i=1, pc_i=7'd20 → halt_o=1, halted_o=1, pc_o=20; then 5 edges of changing inputs plus flush_i=1 → all outputs frozen; assert reset_i → all outputs 0 and state RUN.
- halt_i=1 with valid_i=0 → halted_o stays 0, halt_o=0, count_o unchanged.
- NB_CNT=3: 9 consecutive valid loads → count_o reads 1..7 and then stays at 7.
